// File: rtl/block_sf_param_pipe.sv
// block_sf_param_pipe: 3-stage (L+R)*Ks and (L-R)*Kd scaler with selectable rounding,
// saturation to W bits and a saturating clip-event counter.
module block_sf_param_pipe #(
  parameter int W  = 18,
  parameter int KW = 4,
  parameter int CW = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic signed [W-1:0] LEFT,
  input  logic signed [W-1:0] RIGHT,
  input  logic [KW-1:0]       Ks,
  input  logic [KW-1:0]       Kd,
  input  logic [1:0]          round_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                out_ready,
  output logic signed [W-1:0] LI_in_LpR,
  output logic signed [W-1:0] LI_in_LmR,
  output logic                out_valid,
  output logic                sat_LpR,
  output logic                sat_LmR,
  input  logic                clear_stats,
  output logic [CW-1:0]       sat_count
);
  localparam int PW = W + KW + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (KW - 1);
  localparam logic signed [PW-1:0] MAXV = {{(KW + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  logic                 en;
  logic                 v1_q, v2_q, v3_q;
  logic signed [W:0]    sum_q, dif_q, sum_d, dif_d;
  logic [KW-1:0]        ks_q, kd_q;
  logic [1:0]           rm1_q, rm2_q;
  logic signed [PW-1:0] ps_q, pd_q, ps_d, pd_d, rs, rd;
  logic signed [W-1:0]  lpr_d, lmr_d;
  logic                 slp_d, slm_d;
  logic [CW-1:0]        cnt_d;

  // Convergent skips the bump only on an exact half with an even kept LSB.
  function automatic logic signed [PW-1:0] rnd(input logic signed [PW-1:0] p, input logic [1:0] m);
    logic up;
    up = m != 2'b00 && !(m == 2'b10 && p[KW-1:0] == HALF[KW-1:0] && !p[KW]);
    return $signed(p + (up ? HALF : '0)) >>> KW;
  endfunction

  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign sum_d     = (W + 1)'(LEFT) + (W + 1)'(RIGHT);
  assign dif_d     = (W + 1)'(LEFT) - (W + 1)'(RIGHT);
  assign ps_d      = PW'(sum_q) * PW'($signed({1'b0, ks_q}));
  assign pd_d      = PW'(dif_q) * PW'($signed({1'b0, kd_q}));
  assign rs        = rnd(ps_q, rm2_q);
  assign rd        = rnd(pd_q, rm2_q);
  assign slp_d     = rs > MAXV || rs < MINV;
  assign slm_d     = rd > MAXV || rd < MINV;
  assign lpr_d     = rs > MAXV ? MAXV[W-1:0] : rs < MINV ? MINV[W-1:0] : rs[W-1:0];
  assign lmr_d     = rd > MAXV ? MAXV[W-1:0] : rd < MINV ? MINV[W-1:0] : rd[W-1:0];
  assign cnt_d     = clear_stats ? '0 :
                     (v3_q && out_ready && (sat_LpR || sat_LmR) && !(&sat_count)) ? sat_count + 1'b1 : sat_count;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {v1_q, v2_q, v3_q} <= '0;
      {sum_q, dif_q}     <= '0;
      {ks_q, kd_q}       <= '0;
      {rm1_q, rm2_q}     <= '0;
      {ps_q, pd_q}       <= '0;
      LI_in_LpR          <= '0;
      LI_in_LmR          <= '0;
      sat_LpR            <= 1'b0;
      sat_LmR            <= 1'b0;
    end else if (en) begin
      v1_q      <= in_valid;
      sum_q     <= sum_d;
      dif_q     <= dif_d;
      ks_q      <= Ks;
      kd_q      <= Kd;
      rm1_q     <= round_mode;
      v2_q      <= v1_q;
      ps_q      <= ps_d;
      pd_q      <= pd_d;
      rm2_q     <= rm1_q;
      v3_q      <= v2_q;
      LI_in_LpR <= lpr_d;
      LI_in_LmR <= lmr_d;
      sat_LpR   <= v2_q && slp_d;
      sat_LmR   <= v2_q && slm_d;
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) sat_count <= '0;
    else sat_count <= cnt_d;
endmodule

// File: tb/tb_block_sf_param_pipe.sv
// tb_block_sf_param_pipe: scoreboard bench for the sum/difference scaler pipeline.
module tb_block_sf_param_pipe;
  localparam int W  = 18;
  localparam int KW = 4;
  localparam int CW = 4;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));
  localparam longint HALF = longint'(1) <<< (KW - 1);

  logic                clock, reset;
  logic signed [W-1:0] LEFT, RIGHT;
  logic [KW-1:0]       Ks, Kd;
  logic [1:0]          round_mode;
  logic                in_valid, in_ready, out_ready, out_valid;
  logic signed [W-1:0] LI_in_LpR, LI_in_LmR;
  logic                sat_LpR, sat_LmR, clear_stats;
  logic [CW-1:0]       sat_count;

  typedef struct {
    longint lpr;
    longint lmr;
    bit     slp;
    bit     slm;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     nchk, nfail, exp_cnt;
  bit     held, done, xs;
  longint hl, hm;

  block_sf_param_pipe #(.W(W), .KW(KW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .LEFT(LEFT), .RIGHT(RIGHT), .Ks(Ks), .Kd(Kd),
    .round_mode(round_mode), .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .LI_in_LpR(LI_in_LpR), .LI_in_LmR(LI_in_LmR), .out_valid(out_valid), .sat_LpR(sat_LpR),
    .sat_LmR(sat_LmR), .clear_stats(clear_stats), .sat_count(sat_count)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint rnd(input longint s, input longint k, input int m);
    longint p, q, rem;
    p   = s * k;
    q   = p >>> KW;
    rem = p - (q <<< KW);
    if (m == 0) return q;
    if (m == 2) return (rem > HALF || (rem == HALF && q[0])) ? q + 1 : q;
    return rem >= HALF ? q + 1 : q;
  endfunction

  function automatic exp_t model(input logic signed [W-1:0] l, input logic signed [W-1:0] r,
                                 input logic [KW-1:0] ks, input logic [KW-1:0] kd, input logic [1:0] m);
    exp_t   x;
    longint a, b;
    a     = rnd(longint'(l) + longint'(r), longint'(ks), int'(m));
    b     = rnd(longint'(l) - longint'(r), longint'(kd), int'(m));
    x.slp = a > MAXV || a < MINV;
    x.slm = b > MAXV || b < MINV;
    x.lpr = a > MAXV ? MAXV : a < MINV ? MINV : a;
    x.lmr = b > MAXV ? MAXV : b < MINV ? MINV : b;
    return x;
  endfunction

  // Transfers are judged at the falling edge, where inputs and outputs are settled.
  always @(negedge clock) begin
    if (reset) begin
      check("in_ready", in_ready, !out_valid || out_ready);
      check("sat_count", sat_count, exp_cnt);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_lpr", LI_in_LpR, hl);
        check("hold_lmr", LI_in_LmR, hm);
      end
      held = out_valid && !out_ready;
      hl   = LI_in_LpR;
      hm   = LI_in_LmR;
      xs   = 0;
      if (in_valid && in_ready) sb.push_back(model(LEFT, RIGHT, Ks, Kd, round_mode));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("lpr", LI_in_LpR, e.lpr);
          check("lmr", LI_in_LmR, e.lmr);
          check("sat_lpr", sat_LpR, e.slp);
          check("sat_lmr", sat_LmR, e.slm);
          xs = e.slp || e.slm;
        end
      end
      exp_cnt = clear_stats ? 0 : (xs && exp_cnt < (1 << CW) - 1) ? exp_cnt + 1 : exp_cnt;
    end else held = 0;
  end

  task automatic send(input logic signed [W-1:0] l, input logic signed [W-1:0] r,
                      input logic [KW-1:0] ks, input logic [KW-1:0] kd, input logic [1:0] m);
    int n;
    bit acc;
    n = 0;
    LEFT = l; RIGHT = r; Ks = ks; Kd = kd; round_mode = m; in_valid = 1;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 0;
    LEFT = W'($urandom); RIGHT = W'($urandom); Ks = KW'($urandom); Kd = KW'($urandom);
    round_mode = 2'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      @(posedge clock); #1;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; out_ready = 1; clear_stats = 0;
    LEFT = 0; RIGHT = 0; Ks = 0; Kd = 0; round_mode = 0;
    #2 reset = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_lpr", LI_in_LpR, 0);
    check("rst_lmr", LI_in_LmR, 0);
    check("rst_sat_flags", {sat_LpR, sat_LmR}, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock); #3 reset = 1;
    @(posedge clock); #1;

    send(15, 32, 8, 12, 1);
    check("lat_c0", out_valid, 0);
    @(posedge clock); #1;
    check("lat_c1", out_valid, 0);
    @(posedge clock); #1;
    check("lat_c2_valid", out_valid, 1);
    check("basic_lpr", LI_in_LpR, 24);
    check("basic_lmr", LI_in_LmR, -13);
    check("basic_sat", {sat_LpR, sat_LmR}, 0);
    drain();

    for (int m = 0; m < 4; m++) send(13, 32, 8, 3, 2'(m));
    send(131071, 131071, 15, 15, 1);
    send(-131072, 131071, 15, 15, 1);
    send(1000, -5, 0, 0, 1);
    send(-131072, -131072, 15, 0, 2);
    drain();

    fork
      for (int i = 0; i < 8; i++) send(W'(i * 977 - 3000), W'(i * 55), KW'(i + 3), KW'(15 - i), 2'(i));
      begin
        repeat (4) @(posedge clock);
        #1 out_ready = 0;
        repeat (4) @(posedge clock);
        #1 out_ready = 1;
      end
    join
    drain();

    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom), KW'($urandom), KW'($urandom), 2'($urandom));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clock); #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1;
      end
    join
    drain();

    for (int i = 0; i < 20; i++) send(131071, -131072, 15, 15, 2'(i));
    drain();
    check("sat_count_hold", sat_count, 15);
    send(131071, 131071, 15, 1, 1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("clr_beat_valid", out_valid, 1);
    clear_stats = 1;
    @(posedge clock); #1;
    clear_stats = 0;
    check("clear_wins", sat_count, 0);
    drain();

    send(131071, 131071, 15, 15, 0);
    send(100, 200, 5, 6, 1);
    #2 reset = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_lpr", LI_in_LpR, 0);
    sb.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clock);
    #3 reset = 1;
    repeat (6) begin
      @(posedge clock); #1;
      check("no_stale", out_valid, 0);
    end
    send(-7, 9, 9, 7, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
